// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Desc     : Sequencing controller between the M-extension issue front end and
//            a multi-cycle divider. Accepts one DIV/DIVU/REM/REMU request at a
//            time, resolves divide-by-zero and signed overflow locally,
//            otherwise launches the divider under a watchdog and returns the
//            selected quotient/remainder over a valid/ready response port.
// Options  : `define DIV_REUSE_EN keeps the operands and results of the last
//            divider run so that a repeated a/b/signedness request (e.g. DIV
//            then REM) is answered without restarting the divider.
// Revision : 1.0 - initial release
// ============================================================================
module div_ctrl #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic             div_start,
    output logic             div_unsigned,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    input  logic             div_done,
    output logic             busy
);

    // Watchdog only has to count up to TIMEOUT_CYCLES-1.
    localparam int                WD_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]   c_wd_last = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WIDTH-1:0]  c_ones    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  c_int_min = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic [WIDTH-1:0] r_resp_data;
    logic             r_div_start;
    logic             r_div_unsigned;
    logic [WIDTH-1:0] r_div_a;
    logic [WIDTH-1:0] r_div_b;
    logic             r_busy;
    logic             r_rem;          // latched op[1]: return remainder
    logic [WD_W-1:0]  r_wd;

    logic             w_b_zero;
    logic             w_ovf;
    logic             w_wd_expire;
    logic             w_div_finish;
    logic             w_reuse_hit;
    logic [WIDTH-1:0] w_reuse_q;
    logic [WIDTH-1:0] w_reuse_r;

    // Special cases are evaluated on the latched operands during CHECK.
    assign w_b_zero     = (r_div_b == '0);
    assign w_ovf        = !r_div_unsigned && (r_div_a == c_int_min) && (r_div_b == c_ones);
    // div_done has priority over the watchdog in the same cycle.
    assign w_div_finish = (r_state == S_WAIT) && div_done;
    assign w_wd_expire  = (r_state == S_WAIT) && !div_done && (r_wd == c_wd_last);

`ifdef DIV_REUSE_EN
    logic             r_st_valid;
    logic             r_st_unsigned;
    logic [WIDTH-1:0] r_st_a;
    logic [WIDTH-1:0] r_st_b;
    logic [WIDTH-1:0] r_st_q;
    logic [WIDTH-1:0] r_st_r;

    assign w_reuse_hit = r_st_valid && (r_st_a == r_div_a) && (r_st_b == r_div_b)
                         && (r_st_unsigned == r_div_unsigned);
    assign w_reuse_q   = r_st_q;
    assign w_reuse_r   = r_st_r;

    // Remember the last divider result; a watchdog abort invalidates it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_st_valid    <= 1'b0;
            r_st_unsigned <= 1'b0;
            r_st_a        <= '0;
            r_st_b        <= '0;
            r_st_q        <= '0;
            r_st_r        <= '0;
        end else if (w_div_finish) begin
            r_st_valid    <= 1'b1;
            r_st_unsigned <= r_div_unsigned;
            r_st_a        <= r_div_a;
            r_st_b        <= r_div_b;
            r_st_q        <= div_q;
            r_st_r        <= div_r;
        end else if (w_wd_expire) begin
            r_st_valid    <= 1'b0;
        end
    end
`else
    assign w_reuse_hit = 1'b0;
    assign w_reuse_q   = '0;
    assign w_reuse_r   = '0;
`endif

    // Control FSM; every output is a register updated on state transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_err     <= 1'b0;
            r_resp_data    <= '0;
            r_div_start    <= 1'b0;
            r_div_unsigned <= 1'b0;
            r_div_a        <= '0;
            r_div_b        <= '0;
            r_busy         <= 1'b0;
            r_rem          <= 1'b0;
            r_wd           <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_div_a        <= req_a;
                        r_div_b        <= req_b;
                        r_div_unsigned <= req_op[0];
                        r_rem          <= req_op[1];
                        r_req_ready    <= 1'b0;
                        r_busy         <= 1'b1;
                        r_state        <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_b_zero) begin
                        r_resp_data  <= r_rem ? r_div_a : c_ones;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (w_ovf) begin
                        r_resp_data  <= r_rem ? '0 : r_div_a;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (w_reuse_hit) begin
                        r_resp_data  <= r_rem ? w_reuse_r : w_reuse_q;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_div_start  <= 1'b1;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    r_div_start <= 1'b0;
                    r_wd        <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    r_wd <= r_wd + WD_W'(1);
                    if (div_done) begin
                        r_resp_data  <= r_rem ? div_r : div_q;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (r_wd == c_wd_last) begin
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_err     = r_resp_err;
    assign resp_data    = r_resp_data;
    assign div_start    = r_div_start;
    assign div_unsigned = r_div_unsigned;
    assign div_a        = r_div_a;
    assign div_b        = r_div_b;
    assign busy         = r_busy;

endmodule
`default_nettype wire
